// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for IF / MEM / loader. Writes complete at gnt; reads return rvalid RD_LAT+1 cycles after gnt.
// Requesters hold req until gnt. Define ARB_RR_EN for data/fetch round-robin; the default is fixed loader > data > fetch.
module mips32_mem_arbiter #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          halted,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    lat_q, lat_d;
    logic [DW-1:0] if_rdata_q, dm_rdata_q;
    logic          ld_elig, dm_first, pick_dm, pick_if;

`ifdef ARB_RR_EN
    // rr_q = 1 means data wins the next data/fetch tie.
    logic rr_q, rr_d;

    assign dm_first = rr_q;

    always_comb begin
        rr_d = rr_q;
        if (dm_gnt) begin
            rr_d = 1'b0;
        end else if (if_gnt) begin
            rr_d = 1'b1;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign dm_first = 1'b1;
`endif

    assign ld_elig = ld_req & halted;
    assign pick_dm = !ld_elig && dm_req && (dm_first || !if_req);
    assign pick_if = !ld_elig && if_req && !pick_dm;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        ld_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == S_WAIT) begin
            // Every latency cycle is spent in WAIT so the capture is always registered.
            if (lat_q == 2'd0) begin
                state_d = S_RESP;
            end else begin
                lat_d = lat_q - 2'd1;
            end
        end else begin
            state_d = S_IDLE;
            if (ld_elig) begin
                ld_gnt    = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
            end else if (pick_dm) begin
                dm_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_addr = dm_addr;
                if (dm_we) begin
                    mem_we    = 1'b1;
                    mem_wdata = dm_wdata;
                end else begin
                    owner_d = OWN_DM;
                    state_d = S_WAIT;
                    lat_d   = LAT_INIT;
                end
            end else if (pick_if) begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_addr = if_addr;
                owner_d  = OWN_IF;
                state_d  = S_WAIT;
                lat_d    = LAT_INIT;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_NONE;
            lat_q      <= 2'd0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
            if (state_q == S_WAIT && lat_q == 2'd0) begin
                if (owner_q == OWN_IF) begin
                    if_rdata_q <= mem_rdata;
                end
                if (owner_q == OWN_DM) begin
                    dm_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign if_rvalid = (state_q == S_RESP) && (owner_q == OWN_IF);
    assign dm_rvalid = (state_q == S_RESP) && (owner_q == OWN_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = (state_q == S_WAIT);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter with RD_LAT=2 and a latency-accurate memory model.
module tb_mips32_mem_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk1, rst, halted;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          ld_req, ld_gnt;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:LAT-1];

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
        .clk1(clk1), .rst(rst), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    always @(posedge clk1) begin
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    task automatic mid;
        @(negedge clk1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick; mid;
        checks++;
        if ({if_gnt, dm_gnt, ld_gnt, mem_en, mem_we, busy, if_rvalid, dm_rvalid} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {if_gnt, dm_gnt, ld_gnt, mem_en, mem_we, busy, if_rvalid, dm_rvalid});
        end
        checks++;
        if ({if_rdata, dm_rdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h %h expected 0 0", if_rdata, dm_rdata);
        end
        tick;
        rst = 1'b0;
    endtask

    task automatic test_loader;
        halted = 1'b1; ld_req = 1'b1; ld_addr = 10'd0; ld_wdata = 32'h2801000a;
        mid;
        checks++;
        if ({ld_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd0, 32'h2801000a}) begin
            errors++;
            $display("FAIL ld_write0: got %b %h %h expected 111 0 2801000a", {ld_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        tick;
        ld_addr = 10'd8; ld_wdata = 32'hfc000000;
        mid;
        checks++;
        if ({ld_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd8, 32'hfc000000}) begin
            errors++;
            $display("FAIL ld_write8: got %b %h %h expected 111 8 fc000000", {ld_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        tick;
        ld_req = 1'b0; halted = 1'b0;
        mid;
        checks++;
        if ({ld_gnt, mem_en} !== 2'b00 || mem[0] !== 32'h2801000a || mem[8] !== 32'hfc000000) begin
            errors++;
            $display("FAIL ld_done: got gnt/en %b mem0 %h mem8 %h expected 00 2801000a fc000000", {ld_gnt, mem_en}, mem[0], mem[8]);
        end
        tick;
    endtask

    task automatic test_fetch_read;
        if_req = 1'b1; if_addr = 10'd0;
        mid;
        checks++;
        if ({if_gnt, mem_en, mem_we, busy, mem_addr} !== {4'b1100, 10'd0}) begin
            errors++;
            $display("FAIL if_grant: got %b %h expected 1100 0", {if_gnt, mem_en, mem_we, busy}, mem_addr);
        end
        tick;
        if_req = 1'b0;
        mid;
        checks++;
        if ({busy, if_gnt, mem_en, if_rvalid} !== 4'b1000) begin
            errors++;
            $display("FAIL if_wait1: got %b expected 1000", {busy, if_gnt, mem_en, if_rvalid});
        end
        tick; mid;
        checks++;
        if ({busy, if_rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL if_wait2: got %b expected 10", {busy, if_rvalid});
        end
        tick; mid;
        checks++;
        if ({if_rvalid, busy, if_rdata} !== {2'b10, 32'h2801000a}) begin
            errors++;
            $display("FAIL if_resp: got %b %h expected 10 2801000a", {if_rvalid, busy}, if_rdata);
        end
        tick; mid;
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b0, 32'h2801000a}) begin
            errors++;
            $display("FAIL if_hold: got %b %h expected 0 2801000a", if_rvalid, if_rdata);
        end
        tick;
    endtask

    task automatic test_priority;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd8;
        if_req = 1'b1; if_addr = 10'd0;
        mid;
        checks++;
        if ({dm_gnt, if_gnt, mem_addr} !== {2'b10, 10'd8}) begin
            errors++;
            $display("FAIL prio_first: got %b %h expected 10 8", {dm_gnt, if_gnt}, mem_addr);
        end
        tick;
        dm_req = 1'b0;
        mid;
        checks++;
        if ({if_gnt, busy} !== 2'b01) begin
            errors++;
            $display("FAIL prio_wait: got %b expected 01", {if_gnt, busy});
        end
        tick; tick; mid;
        checks++;
        if ({dm_rvalid, if_gnt, mem_addr, dm_rdata} !== {2'b11, 10'd0, 32'hfc000000}) begin
            errors++;
            $display("FAIL prio_overlap: got %b %h %h expected 11 0 fc000000", {dm_rvalid, if_gnt}, mem_addr, dm_rdata);
        end
        tick;
        if_req = 1'b0;
        tick; tick; mid;
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h2801000a}) begin
            errors++;
            $display("FAIL prio_if_resp: got %b %h expected 1 2801000a", if_rvalid, if_rdata);
        end
        tick;
    endtask

    task automatic test_held;
        logic exp_dm;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd8;
        if_req = 1'b1; if_addr = 10'd0;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_dm = (k % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            mid;
            checks++;
            if ({dm_gnt, if_gnt} !== {exp_dm, !exp_dm}) begin
                errors++;
                $display("FAIL held_grant%0d: got %b expected %b", k, {dm_gnt, if_gnt}, {exp_dm, !exp_dm});
            end
            tick; tick; tick;
        end
        dm_req = 1'b0; if_req = 1'b0;
        tick; tick; tick; tick;
    endtask

    task automatic test_halted;
        halted = 1'b0; ld_req = 1'b1; ld_addr = 10'd3; ld_wdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            mid;
            checks++;
            if ({ld_gnt, mem_en} !== 2'b00) begin
                errors++;
                $display("FAIL ld_not_halted%0d: got %b expected 00", i, {ld_gnt, mem_en});
            end
            tick;
        end
        halted = 1'b1;
        mid;
        checks++;
        if ({ld_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 10'd3, 32'h12345678}) begin
            errors++;
            $display("FAIL ld_halted: got %b %h %h expected 11 3 12345678", {ld_gnt, mem_we}, mem_addr, mem_wdata);
        end
        tick;
        ld_req = 1'b0; halted = 1'b0;
        tick;
    endtask

    task automatic test_store_load;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd5; dm_wdata = 32'h00222000;
        mid;
        checks++;
        if ({dm_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd5, 32'h00222000}) begin
            errors++;
            $display("FAIL st_grant: got %b %h %h expected 111 5 00222000", {dm_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        tick;
        dm_we = 1'b0;
        mid;
        checks++;
        if ({dm_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 10'd5}) begin
            errors++;
            $display("FAIL ld_grant: got %b %h expected 110 5", {dm_gnt, mem_en, mem_we}, mem_addr);
        end
        tick;
        dm_req = 1'b0;
        mid;
        checks++;
        if ({dm_rvalid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL st_ld_wait: got %b expected 01", {dm_rvalid, busy});
        end
        tick; tick; mid;
        checks++;
        if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h00222000}) begin
            errors++;
            $display("FAIL st_ld_resp: got %b %h expected 1 00222000", dm_rvalid, dm_rdata);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        logic seen;
        if_req = 1'b1; if_addr = 10'd8;
        mid;
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rm_grant: got %b expected 1", if_gnt);
        end
        tick;
        if_req = 1'b0; rst = 1'b1;
        mid;
        checks++;
        if ({busy, if_rvalid, dm_rvalid, if_gnt, dm_gnt, ld_gnt, mem_en, mem_we, if_rdata, dm_rdata} !== 72'd0) begin
            errors++;
            $display("FAIL rm_outputs: got %b %h %h expected all zero",
                     {busy, if_rvalid, dm_rvalid, if_gnt, dm_gnt, ld_gnt, mem_en, mem_we}, if_rdata, dm_rdata);
        end
        tick;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid;
            if (if_rvalid || busy) seen = 1'b1;
            tick;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rm_no_rvalid: got %b expected 0", seen);
        end
        if_req = 1'b1; if_addr = 10'd8;
        mid;
        checks++;
        if ({if_gnt, mem_addr} !== {1'b1, 10'd8}) begin
            errors++;
            $display("FAIL rm_regrant: got %b %h expected 1 8", if_gnt, mem_addr);
        end
        tick;
        if_req = 1'b0;
        tick; tick; mid;
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'hfc000000}) begin
            errors++;
            $display("FAIL rm_resp: got %b %h expected 1 fc000000", if_rvalid, if_rdata);
        end
        tick;
    endtask

    initial begin
        rst = 1'b1; halted = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        test_reset;
        test_loader;
        test_fetch_read;
        test_priority;
        test_held;
        test_halted;
        test_store_load;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
